// File: rtl/dtw_feed_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : dtw_feed_ctrl_if
// Brief    : Query stream, reference memory, core and result signals of the
//            DTW feed controller, bundled with controller/environment views.
// Revision : 1.0 - initial release
// ============================================================================
interface dtw_feed_ctrl_if #(
    parameter int width  = 16,
    parameter int ADDR_W = 20
);
    logic              start;
    logic [31:0]       ref_len;
    logic              sq_valid;
    logic [width-1:0]  sq_data;
    logic              sq_ready;
    logic              ref_rd;
    logic [ADDR_W-1:0] ref_addr;
    logic [width-1:0]  ref_data;
    logic              core_rst;
    logic              core_running;
    logic [width-1:0]  core_squiggle;
    logic [width-1:0]  core_rword;
    logic [width-1:0]  core_minval;
    logic [31:0]       core_position;
    logic              core_done;
    logic              res_valid;
    logic              res_ready;
    logic [width-1:0]  res_minval;
    logic [31:0]       res_position;
    logic              busy;

    modport master (
        input  start, ref_len, sq_valid, sq_data, ref_data,
               core_minval, core_position, core_done, res_ready,
        output sq_ready, ref_rd, ref_addr, core_rst, core_running,
               core_squiggle, core_rword, res_valid, res_minval,
               res_position, busy
    );

    modport slave (
        output start, ref_len, sq_valid, sq_data, ref_data,
               core_minval, core_position, core_done, res_ready,
        input  sq_ready, ref_rd, ref_addr, core_rst, core_running,
               core_squiggle, core_rword, res_valid, res_minval,
               res_position, busy
    );
endinterface
`default_nettype wire

// File: rtl/dtw_feed_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dtw_feed_ctrl
// Brief    : Sequences one query and the reference stream into the DTW core,
//            flushes it and returns the captured minimum and position.
// Revision : 1.0 - initial release
// ============================================================================
module dtw_feed_ctrl #(
    parameter int width    = 16,
    parameter int SQG_SIZE = 250,
    parameter int ADDR_W   = 20
) (
    input  logic            clk,
    input  logic            rst_n,
    dtw_feed_ctrl_if.master bus
);
    localparam logic [width-1:0] c_PAD = '1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PRIME  = 3'd1,
        S_STREAM = 3'd2,
        S_FLUSH  = 3'd3,
        S_RESULT = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [31:0]      r_beat;
    logic [31:0]      r_ref_len;
    logic             r_flush_last;
    logic             r_rd_pending;
    logic [width-1:0] r_rword_hold;
    logic [width-1:0] r_res_minval;
    logic [31:0]      r_res_position;

    logic             w_sq_ready;
    logic             w_running;
    logic             w_rd;
    logic [width-1:0] w_squiggle;
    logic [width-1:0] w_rword;
    logic [width-1:0] w_word;

    always_comb begin
        w_state_nxt = r_state;
        w_sq_ready  = 1'b0;
        w_running   = 1'b0;
        w_rd        = 1'b0;
        w_squiggle  = '0;
        w_rword     = c_PAD;
        // Fresh read data is only on the bus for one cycle; afterwards the hold copy stands in.
        w_word      = r_rd_pending ? bus.ref_data : r_rword_hold;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = (bus.ref_len == 32'd0) ? S_RESULT : S_PRIME;
                end
            end
            S_PRIME: begin
                w_state_nxt = S_STREAM;
            end
            S_STREAM: begin
                if (r_beat == 32'd0) begin
                    w_running = 1'b1;
                end else if (r_beat <= 32'(SQG_SIZE)) begin
                    w_sq_ready = 1'b1;
                    w_running  = bus.sq_valid;
                    w_squiggle = bus.sq_data;
                end else begin
                    w_running = 1'b1;
                end
                if ((r_beat != 32'd0) && (r_beat <= r_ref_len)) begin
                    w_rword = w_word;
                end
                w_rd = w_running && (r_beat < r_ref_len);
                if (w_running && bus.core_done) begin
                    w_state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                w_running = 1'b1;
                if (r_flush_last) begin
                    w_state_nxt = S_RESULT;
                end
            end
            S_RESULT: begin
                if (bus.res_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_beat         <= '0;
            r_ref_len      <= '0;
            r_flush_last   <= 1'b0;
            r_rd_pending   <= 1'b0;
            r_rword_hold   <= c_PAD;
            r_res_minval   <= c_PAD;
            r_res_position <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_rd_pending <= w_rd;
            if (r_rd_pending) begin
                r_rword_hold <= bus.ref_data;
            end
            if ((r_state == S_IDLE) && bus.start) begin
                r_ref_len <= bus.ref_len;
            end
            if (r_state == S_PRIME) begin
                r_beat <= '0;
            end else if ((r_state == S_STREAM) && w_running) begin
                r_beat <= r_beat + 32'd1;
            end
            r_flush_last <= (r_state == S_FLUSH) ? ~r_flush_last : 1'b0;
            if ((r_state == S_IDLE) && bus.start && (bus.ref_len == 32'd0)) begin
                r_res_minval   <= c_PAD;
                r_res_position <= '0;
            end else if ((r_state == S_FLUSH) && (w_state_nxt == S_RESULT)) begin
                r_res_minval   <= bus.core_minval;
                r_res_position <= bus.core_position;
            end
        end
    end

    assign bus.sq_ready      = w_sq_ready;
    assign bus.core_running  = w_running;
    assign bus.core_squiggle = w_squiggle;
    assign bus.core_rword    = w_rword;
    assign bus.ref_rd        = w_rd;
    assign bus.ref_addr      = w_rd ? r_beat[ADDR_W-1:0] : '0;
    assign bus.core_rst      = (r_state == S_IDLE) || (r_state == S_PRIME);
    assign bus.res_valid     = (r_state == S_RESULT);
    assign bus.res_minval    = r_res_minval;
    assign bus.res_position  = r_res_position;
    assign bus.busy          = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dtw_feed_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dtw_feed_ctrl
// Brief    : Self-checking bench for dtw_feed_ctrl with a reference memory,
//            a counting core stand-in and a beat-level expectation model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dtw_feed_ctrl;
    localparam int W   = 16;
    localparam int SQG = 4;
    localparam int AW  = 20;
    localparam logic [W-1:0] PAD = '1;
    localparam logic [105:0] RST_OUTS = {1'b0, 1'b0, {AW{1'b0}}, 1'b1, 1'b0,
                                         {W{1'b0}}, PAD, 1'b0, PAD, 32'd0, 1'b0};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    dtw_feed_ctrl_if #(.width(W), .ADDR_W(AW)) bus ();
    dtw_feed_ctrl #(.width(W), .SQG_SIZE(SQG), .ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    wire [105:0] outs = {bus.sq_ready, bus.ref_rd, bus.ref_addr, bus.core_rst,
                         bus.core_running, bus.core_squiggle, bus.core_rword,
                         bus.res_valid, bus.res_minval, bus.res_position, bus.busy};

    // Environment: reference memory and a core that reports done after done_at beats.
    logic [W-1:0] mem [0:63];
    logic [W-1:0] q   [0:SQG-1];
    int           done_at = 1000;
    int           core_cnt = 0;
    logic [W-1:0] stub_min = '0;
    logic [31:0]  stub_pos = '0;

    always @(posedge clk) if (bus.ref_rd) bus.ref_data <= mem[bus.ref_addr[5:0]];
    always @(posedge clk) begin
        if (bus.core_rst) core_cnt <= 0;
        else if (bus.core_running) core_cnt <= core_cnt + 1;
    end
    assign bus.core_done     = (core_cnt >= done_at);
    assign bus.core_minval   = stub_min;
    assign bus.core_position = stub_pos;

    logic [W-1:0] mon_sq [$];
    logic [W-1:0] mon_rw [$];
    int           mon_addr [$];
    int           mon_viol = 0;
    always @(negedge clk) if (rst_n) begin
        if (bus.core_running) begin
            mon_sq.push_back(bus.core_squiggle);
            mon_rw.push_back(bus.core_rword);
        end
        if (bus.ref_rd) mon_addr.push_back(int'(bus.ref_addr));
        if (bus.core_running && bus.sq_ready && !bus.sq_valid) mon_viol++;
    end

    // Beat b of a query: samples in beats 1..SQG, word b-1 in beats 1..len, padding elsewhere.
    function automatic logic [W-1:0] exp_sq(int b);
        return (b >= 1 && b <= SQG) ? q[b-1] : '0;
    endfunction
    function automatic logic [W-1:0] exp_rw(int b, int len);
        return (b >= 1 && b <= len && b <= done_at) ? mem[b-1] : PAD;
    endfunction

    logic [W-1:0] res_min;
    logic [31:0]  res_pos;
    int           t_res;
    bit           timed_out;
    logic         rst_at1, rst_at2, busy_after;

    task automatic do_query(input int len, input bit stall, input bit hold);
        int  k;
        int  idx;
        bit  hs;
        bit  got;
        k = 0; idx = 0; got = 0; timed_out = 0;
        mon_sq.delete(); mon_rw.delete(); mon_addr.delete(); mon_viol = 0;
        bus.res_ready = !hold;
        bus.start = 1'b1;
        bus.ref_len = len;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.ref_len = $urandom;
        while (!got && k < 300) begin
            k++;
            bus.sq_valid = (idx < SQG) && (!stall || (k % 2 == 1));
            bus.sq_data  = bus.sq_valid ? q[idx] : W'($urandom);
            @(negedge clk);
            if (k == 1) rst_at1 = bus.core_rst;
            if (k == 2) rst_at2 = bus.core_rst;
            hs = bus.sq_valid && bus.sq_ready;
            if (bus.res_valid) begin
                got = 1; t_res = k; res_min = bus.res_minval; res_pos = bus.res_position;
            end
            @(posedge clk); #1;
            if (hs) idx++;
        end
        bus.sq_valid = 1'b0;
        busy_after = bus.busy;
        if (!got) timed_out = 1;
    endtask

    task automatic load_case1();
        logic [W-1:0] r [0:7];
        r = '{16'd9, 16'd9, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9, 16'd9};
        for (int i = 0; i < 8; i++) mem[i] = r[i];
        q[0] = 16'd5; q[1] = 16'd6; q[2] = 16'd7; q[3] = 16'd8;
        done_at = 9;
        stub_min = 16'd0;
        stub_pos = 32'd5;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (outs !== RST_OUTS) begin n_errors++; $display("FAIL reset_hold got %h want %h", outs, RST_OUTS); end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (outs !== RST_OUTS) begin n_errors++; $display("FAIL reset_idle got %h want %h", outs, RST_OUTS); end
    endtask

    task automatic test_basic();
        load_case1();
        do_query(8, 0, 0);
        n_checks++;
        if (timed_out) begin n_errors++; $display("FAIL basic_timeout got 1 want 0"); end
        n_checks++;
        if (t_res != done_at + 5) begin n_errors++; $display("FAIL basic_latency got %0d want %0d", t_res, done_at + 5); end
        n_checks++;
        if (res_min !== 16'd0 || res_pos !== 32'd5) begin n_errors++; $display("FAIL basic_result got %0d/%0d want 0/5", res_min, res_pos); end
        n_checks++;
        if (rst_at1 !== 1'b1 || rst_at2 !== 1'b0) begin n_errors++; $display("FAIL basic_prime_rst got %b%b want 10", rst_at1, rst_at2); end
        n_checks++;
        if (busy_after !== 1'b0) begin n_errors++; $display("FAIL basic_busy_exit got %b want 0", busy_after); end
        n_checks++;
        if (mon_sq.size() != done_at + 3) begin n_errors++; $display("FAIL basic_beats got %0d want %0d", mon_sq.size(), done_at + 3); end
        for (int b = 0; b < mon_sq.size() && b < done_at + 3; b++) begin
            n_checks++;
            if (mon_sq[b] !== exp_sq(b) || mon_rw[b] !== exp_rw(b, 8)) begin
                n_errors++; $display("FAIL basic_beat%0d got %h/%h want %h/%h", b, mon_sq[b], mon_rw[b], exp_sq(b), exp_rw(b, 8));
            end
        end
        n_checks++;
        if (mon_addr.size() != 8) begin n_errors++; $display("FAIL basic_reads got %0d want 8", mon_addr.size()); end
        for (int i = 0; i < mon_addr.size() && i < 8; i++) begin
            n_checks++;
            if (mon_addr[i] != i) begin n_errors++; $display("FAIL basic_addr%0d got %0d want %0d", i, mon_addr[i], i); end
        end
    endtask

    task automatic test_stall();
        load_case1();
        do_query(8, 1, 0);
        n_checks++;
        if (timed_out || res_min !== 16'd0 || res_pos !== 32'd5) begin
            n_errors++; $display("FAIL stall_result got %0d/%0d to=%0d want 0/5", res_min, res_pos, timed_out);
        end
        n_checks++;
        if (mon_viol != 0) begin n_errors++; $display("FAIL stall_running got %0d stalled beats want 0", mon_viol); end
        n_checks++;
        if (mon_sq.size() != done_at + 3) begin n_errors++; $display("FAIL stall_beats got %0d want %0d", mon_sq.size(), done_at + 3); end
        for (int b = 0; b < mon_sq.size() && b < done_at + 3; b++) begin
            n_checks++;
            if (mon_sq[b] !== exp_sq(b) || mon_rw[b] !== exp_rw(b, 8)) begin
                n_errors++; $display("FAIL stall_beat%0d got %h/%h want %h/%h", b, mon_sq[b], mon_rw[b], exp_sq(b), exp_rw(b, 8));
            end
        end
        n_checks++;
        if (mon_addr.size() != 8) begin n_errors++; $display("FAIL stall_reads got %0d want 8", mon_addr.size()); end
        for (int i = 0; i < mon_addr.size() && i < 8; i++) begin
            n_checks++;
            if (mon_addr[i] != i) begin n_errors++; $display("FAIL stall_addr%0d got %0d want %0d", i, mon_addr[i], i); end
        end
    endtask

    task automatic test_zero_len();
        stub_min = 16'h1234;
        stub_pos = 32'd77;
        done_at  = 0;
        do_query(0, 0, 0);
        n_checks++;
        if (timed_out || t_res != 1) begin n_errors++; $display("FAIL zero_latency got %0d want 1", t_res); end
        n_checks++;
        if (res_min !== PAD || res_pos !== 32'd0) begin n_errors++; $display("FAIL zero_result got %h/%0d want ffff/0", res_min, res_pos); end
        n_checks++;
        if (mon_addr.size() != 0 || mon_sq.size() != 0) begin
            n_errors++; $display("FAIL zero_activity got %0d reads %0d beats want 0 0", mon_addr.size(), mon_sq.size());
        end
    endtask

    task automatic test_hold();
        logic [W-1:0] want_min;
        logic [31:0]  want_pos;
        for (int i = 0; i < 8; i++) mem[i] = W'($urandom);
        for (int i = 0; i < SQG; i++) q[i] = W'($urandom);
        done_at  = SQG;
        stub_min = W'($urandom);
        stub_pos = $urandom;
        want_min = stub_min;
        want_pos = stub_pos;
        do_query(3, 0, 1);
        stub_min = ~stub_min;
        stub_pos = stub_pos + 32'd1;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin bus.start = 1'b1; bus.ref_len = 32'd5; end
            @(negedge clk);
            n_checks++;
            if (bus.res_valid !== 1'b1 || bus.res_minval !== want_min || bus.res_position !== want_pos) begin
                n_errors++; $display("FAIL hold_cycle%0d got %b %h %h want 1 %h %h", i, bus.res_valid, bus.res_minval, bus.res_position, want_min, want_pos);
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0) begin n_errors++; $display("FAIL hold_release got %b%b want 00", bus.busy, bus.res_valid); end
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL hold_start_ignored got busy %b want 0", bus.busy); end
    endtask

    task automatic test_abort();
        bit found;
        found = 0;
        load_case1();
        bus.res_ready = 1'b1;
        bus.sq_valid = 1'b1;
        bus.sq_data = 16'd5;
        bus.start = 1'b1;
        bus.ref_len = 32'd8;
        @(posedge clk); #1 bus.start = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (core_cnt == 3 && bus.core_running) found = 1;
        end
        n_checks++;
        if (!found) begin n_errors++; $display("FAIL abort_reach_beat3 got 0 want 1"); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (outs !== RST_OUTS) begin n_errors++; $display("FAIL abort_outputs got %h want %h", outs, RST_OUTS); end
        bus.sq_valid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin n_errors++; $display("FAIL abort_discard got %b%b want 00", bus.res_valid, bus.busy); end
        do_query(8, 0, 0);
        n_checks++;
        if (timed_out || res_min !== 16'd0 || res_pos !== 32'd5 || mon_addr.size() != 8) begin
            n_errors++; $display("FAIL abort_rerun got %0d/%0d reads %0d want 0/5 reads 8", res_min, res_pos, mon_addr.size());
        end
    endtask

    task automatic test_back_to_back();
        load_case1();
        stub_min = 16'h0042;
        stub_pos = 32'd11;
        do_query(8, 0, 0);
        n_checks++;
        if (timed_out || res_min !== 16'h0042 || res_pos !== 32'd11) begin
            n_errors++; $display("FAIL b2b_first got %h/%0d want 0042/11", res_min, res_pos);
        end
        for (int i = 0; i < 6; i++) mem[i] = W'(100 + i);
        done_at  = 7;
        stub_min = 16'h0777;
        stub_pos = 32'd3;
        do_query(6, 0, 0);
        n_checks++;
        if (timed_out || res_min !== 16'h0777 || res_pos !== 32'd3) begin
            n_errors++; $display("FAIL b2b_second got %h/%0d want 0777/3", res_min, res_pos);
        end
        n_checks++;
        if (rst_at1 !== 1'b1 || rst_at2 !== 1'b0) begin n_errors++; $display("FAIL b2b_prime_rst got %b%b want 10", rst_at1, rst_at2); end
        n_checks++;
        if (mon_sq.size() != done_at + 3 || mon_rw[6] !== 16'd105 || mon_rw[7] !== PAD) begin
            n_errors++; $display("FAIL b2b_stream got %0d beats want %0d", mon_sq.size(), done_at + 3);
        end
    endtask

    task automatic test_random();
        int  len;
        bit  stall;
        for (int it = 0; it < 4; it++) begin
            len = $urandom_range(1, 12);
            stall = 1'($urandom_range(0, 1));
            for (int i = 0; i < 64; i++) mem[i] = W'($urandom);
            for (int i = 0; i < SQG; i++) q[i] = W'($urandom);
            done_at  = ((len > SQG) ? len : SQG) + $urandom_range(0, 3);
            stub_min = W'($urandom);
            stub_pos = $urandom;
            do_query(len, stall, 0);
            n_checks++;
            if (timed_out || res_min !== stub_min || res_pos !== stub_pos) begin
                n_errors++; $display("FAIL rand%0d_result got %h/%h want %h/%h", it, res_min, res_pos, stub_min, stub_pos);
            end
            n_checks++;
            if (mon_sq.size() != done_at + 3) begin n_errors++; $display("FAIL rand%0d_beats got %0d want %0d", it, mon_sq.size(), done_at + 3); end
            for (int b = 0; b < mon_sq.size() && b < done_at + 3; b++) begin
                n_checks++;
                if (mon_sq[b] !== exp_sq(b) || mon_rw[b] !== exp_rw(b, len)) begin
                    n_errors++; $display("FAIL rand%0d_beat%0d got %h/%h want %h/%h", it, b, mon_sq[b], mon_rw[b], exp_sq(b), exp_rw(b, len));
                end
            end
            n_checks++;
            if (mon_addr.size() != len) begin n_errors++; $display("FAIL rand%0d_reads got %0d want %0d", it, mon_addr.size(), len); end
            for (int i = 0; i < mon_addr.size() && i < len; i++) begin
                n_checks++;
                if (mon_addr[i] != i) begin n_errors++; $display("FAIL rand%0d_addr%0d got %0d want %0d", it, i, mon_addr[i], i); end
            end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.ref_len = '0;
        bus.sq_valid = 1'b0;
        bus.sq_data = '0;
        bus.res_ready = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_zero_len();
        test_hold();
        test_abort();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
